// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - cell-state encoding and palette shared by the board renderer
package board_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_state_e;

  localparam logic [11:0] COLOR_WATER  = 12'h03A;
  localparam logic [11:0] COLOR_SHIP   = 12'h888;
  localparam logic [11:0] COLOR_HIT    = 12'hF00;
  localparam logic [11:0] COLOR_MISS   = 12'hFFF;
  localparam logic [11:0] COLOR_GRID   = 12'h444;
  localparam logic [11:0] COLOR_CURSOR = 12'hFF0;

  function automatic logic [11:0] cell_colour(input cell_state_e s);
    logic [11:0] c;
    c = COLOR_WATER;
    case (s)
      EMPTY: c = COLOR_WATER;
      SHIP:  c = COLOR_SHIP;
      HIT:   c = COLOR_HIT;
      MISS:  c = COLOR_MISS;
      default: c = COLOR_WATER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/delay.sv
// rtl/delay.sv - fixed-length register delay line with synchronous clear
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];
  logic [WIDTH-1:0] pipe_d [CLK_DEL];

  // Next state: each stage takes the previous one, stage 0 takes the input
  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Shift register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/board_draw.sv
// rtl/board_draw.sv - overlays the game board onto a VGA stream with a 3-cycle pipeline
module board_draw import board_pkg::*; #(
  parameter int X_POS        = 64,
  parameter int Y_POS        = 64,
  parameter int X_SIZE       = 16,
  parameter int Y_SIZE       = 16,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2,
  parameter int CELL_SHIFT   = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [10:0]                      hcount_in,
  input  logic [10:0]                      vcount_in,
  input  logic                             hsync_in,
  input  logic                             vsync_in,
  input  logic                             hblnk_in,
  input  logic                             vblnk_in,
  input  logic [11:0]                      rgb_in,
  input  logic [X_ADDR_WIDTH-1:0]          cursor_x,
  input  logic [Y_ADDR_WIDTH-1:0]          cursor_y,
  input  logic                             cursor_en,
  output logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0]            read_data,
  output logic [10:0]                      hcount_out,
  output logic [10:0]                      vcount_out,
  output logic                             hsync_out,
  output logic                             vsync_out,
  output logic                             hblnk_out,
  output logic                             vblnk_out,
  output logic [11:0]                      rgb_out
);

  localparam int AW = Y_ADDR_WIDTH + X_ADDR_WIDTH;
  // 12-bit bounds so a pixel left of / above the board never wraps into it
  localparam logic [11:0] X_LO = 12'(X_POS);
  localparam logic [11:0] X_HI = 12'(X_POS + (X_SIZE << CELL_SHIFT));
  localparam logic [11:0] Y_LO = 12'(Y_POS);
  localparam logic [11:0] Y_HI = 12'(Y_POS + (Y_SIZE << CELL_SHIFT));

  logic [11:0] hc, vc, rel_x, rel_y;

  logic                    in_board_q, in_board_d, in_board2_q, in_board2_d;
  logic                    grid_q, grid_d, grid2_q, grid2_d;
  logic [X_ADDR_WIDTH-1:0] cell_x_q, cell_x_d, cell_x2_q, cell_x2_d;
  logic [Y_ADDR_WIDTH-1:0] cell_y_q, cell_y_d, cell_y2_q, cell_y2_d;
  logic [AW-1:0]           read_addr_q, read_addr_d;
  logic [X_ADDR_WIDTH-1:0] cur_x_q, cur_x_d;
  logic [Y_ADDR_WIDTH-1:0] cur_y_q, cur_y_d;
  logic                    cur_en_q, cur_en_d;
  logic                    vblnk_prev_q, vblnk_prev_d;
  logic [11:0]             rgb_out_q, rgb_out_d;

  logic [25:0] timing_dly;
  logic [13:0] pix_dly;
  logic [11:0] rgb_d2;
  logic        hblnk_d2, vblnk_d2;

  delay #(.WIDTH(26), .CLK_DEL(3)) u_timing_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in}),
    .dout (timing_dly)
  );

  // Background colour and blanking travel two stages to meet the stage-3 mux
  delay #(.WIDTH(14), .CLK_DEL(2)) u_pix_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({rgb_in, hblnk_in, vblnk_in}),
    .dout (pix_dly)
  );

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = timing_dly;
  assign {rgb_d2, hblnk_d2, vblnk_d2} = pix_dly;

  // Stage 1: locate the pixel on the board and issue the cell read
  always_comb begin
    hc          = {1'b0, hcount_in};
    vc          = {1'b0, vcount_in};
    rel_x       = hc - X_LO;
    rel_y       = vc - Y_LO;
    in_board_d  = (hc >= X_LO) && (hc < X_HI) && (vc >= Y_LO) && (vc < Y_HI);
    cell_x_d    = X_ADDR_WIDTH'(rel_x >> CELL_SHIFT);
    cell_y_d    = Y_ADDR_WIDTH'(rel_y >> CELL_SHIFT);
    grid_d      = (rel_x[CELL_SHIFT-1:0] == '0) || (rel_y[CELL_SHIFT-1:0] == '0);
    read_addr_d = in_board_d ? {cell_y_d, cell_x_d} : read_addr_q;
  end

  // Stage 2: carry the stage-1 flags while the memory answers
  always_comb begin
    in_board2_d = in_board_q;
    grid2_d     = grid_q;
    cell_x2_d   = cell_x_q;
    cell_y2_d   = cell_y_q;
  end

  // Cursor is only taken on the vblnk rising edge so a frame never tears
  always_comb begin
    vblnk_prev_d = vblnk_in;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    cur_en_d     = cur_en_q;
    if (vblnk_in && !vblnk_prev_q) begin
      cur_x_d  = cursor_x;
      cur_y_d  = cursor_y;
      cur_en_d = cursor_en;
    end
  end

  // Stage 3: final colour by priority blank > background > grid > cursor > cell
  always_comb begin
    rgb_out_d = 12'h000;
    if (hblnk_d2 || vblnk_d2) begin
      rgb_out_d = 12'h000;
    end else if (!in_board2_q) begin
      rgb_out_d = rgb_d2;
    end else if (grid2_q) begin
      rgb_out_d = COLOR_GRID;
    end else if (cur_en_q && (cell_x2_q == cur_x_q) && (cell_y2_q == cur_y_q)) begin
      rgb_out_d = COLOR_CURSOR;
    end else begin
      rgb_out_d = cell_colour(cell_state_e'(2'(read_data)));
    end
  end

  // Pipeline and cursor registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_board_q   <= 1'b0;
      grid_q       <= 1'b0;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      read_addr_q  <= '0;
      in_board2_q  <= 1'b0;
      grid2_q      <= 1'b0;
      cell_x2_q    <= '0;
      cell_y2_q    <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_en_q     <= 1'b0;
      vblnk_prev_q <= 1'b0;
      rgb_out_q    <= 12'h000;
    end else begin
      in_board_q   <= in_board_d;
      grid_q       <= grid_d;
      cell_x_q     <= cell_x_d;
      cell_y_q     <= cell_y_d;
      read_addr_q  <= read_addr_d;
      in_board2_q  <= in_board2_d;
      grid2_q      <= grid2_d;
      cell_x2_q    <= cell_x2_d;
      cell_y2_q    <= cell_y2_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      cur_en_q     <= cur_en_d;
      vblnk_prev_q <= vblnk_prev_d;
      rgb_out_q    <= rgb_out_d;
    end
  end

  assign read_addr = read_addr_q;
  assign rgb_out   = rgb_out_q;

endmodule

// File: tb/tb_board_draw.sv
// tb/tb_board_draw.sv - directed self-checking bench for board_draw
module tb_board_draw;

  localparam logic [11:0] C_WATER  = 12'h03A;
  localparam logic [11:0] C_SHIP   = 12'h888;
  localparam logic [11:0] C_HIT    = 12'hF00;
  localparam logic [11:0] C_MISS   = 12'hFFF;
  localparam logic [11:0] C_GRID   = 12'h444;
  localparam logic [11:0] C_CURSOR = 12'hFF0;
  localparam logic [11:0] BG       = 12'hABC;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [3:0]  cursor_x, cursor_y;
  logic        cursor_en;
  logic [7:0]  read_addr;
  logic [1:0]  read_data;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [1:0]  mem [256];
  logic [45:0] hist [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) read_data <= mem[read_addr];

  board_draw dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .cursor_en  (cursor_en),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic vb, input logic [11:0] rgb);
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    hsync_in = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold3(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic hb, input logic [11:0] exp);
    set_pix(h, v, hb, 1'b0, BG);
    tick(3);
    chk(tag, 64'(rgb_out), 64'(exp));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 2'd0;
    mem[8'h23] = 2'd2;
    mem[8'h24] = 2'd3;
    mem[8'h2F] = 2'd1;
    cursor_x = 4'd0; cursor_y = 4'd0; cursor_en = 1'b0;

    // reset with busy inputs
    rst = 1'b1;
    set_pix(11'd165, 11'd133, 1'b0, 1'b0, BG);
    hsync_in = 1'b1; vsync_in = 1'b1;
    tick(2);
    chk("reset_outputs", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                              vblnk_out, rgb_out, read_addr}), 64'd0);
    rst = 1'b0;

    // random stream left of the board: pure 3-cycle delay
    for (int i = 0; i < 16; i++) begin
      hcount_in = 11'($urandom_range(0, 63));
      vcount_in = 11'($urandom_range(0, 2047));
      hsync_in  = 1'($urandom_range(0, 1));
      vsync_in  = 1'($urandom_range(0, 1));
      hblnk_in  = 1'($urandom_range(0, 1));
      vblnk_in  = 1'($urandom_range(0, 1));
      rgb_in    = 12'($urandom_range(0, 4095));
      hist[i] = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
                 (hblnk_in || vblnk_in) ? 12'h000 : rgb_in};
      tick(1);
      if (i >= 2) begin
        chk("latency_stream", 64'({hcount_out, vcount_out, hsync_out, vsync_out,
                                   hblnk_out, vblnk_out, rgb_out}), 64'(hist[i-2]));
      end
    end
    set_pix(11'd0, 11'd0, 1'b0, 1'b0, BG);
    tick(3);

    // cell read-back: address after one cycle, colour after three
    set_pix(11'd165, 11'd133, 1'b0, 1'b0, BG);
    tick(1);
    chk("read_addr_23", 64'(read_addr), 64'h23);
    tick(2);
    chk("cell_hit", 64'(rgb_out), 64'(C_HIT));

    hold3("cell_miss", 11'd197, 11'd133, 1'b0, C_MISS);
    hold3("cell_water", 11'd229, 11'd133, 1'b0, C_WATER);
    hold3("edge_h63", 11'd63, 11'd133, 1'b0, BG);
    hold3("edge_h64", 11'd64, 11'd133, 1'b0, C_GRID);
    hold3("edge_h575", 11'd575, 11'd133, 1'b0, C_SHIP);
    hold3("edge_h576", 11'd576, 11'd133, 1'b0, BG);
    chk("read_addr_hold", 64'(read_addr), 64'h2F);
    hold3("edge_v63", 11'd165, 11'd63, 1'b0, BG);
    hold3("hblnk_in_board", 11'd165, 11'd133, 1'b1, 12'h000);

    // cursor requested mid-frame must wait for the next vblnk rise
    cursor_x = 4'd5; cursor_y = 4'd7; cursor_en = 1'b1;
    hold3("cursor_mid_frame", 11'd229, 11'd293, 1'b0, C_WATER);
    set_pix(11'd0, 11'd0, 1'b0, 1'b1, BG);
    tick(1);
    cursor_x = 4'd0; cursor_y = 4'd0; cursor_en = 1'b0;
    hold3("cursor_latched", 11'd229, 11'd293, 1'b0, C_CURSOR);
    hold3("cursor_grid", 11'd224, 11'd293, 1'b0, C_GRID);
    hold3("cursor_other_cell", 11'd69, 11'd69, 1'b0, C_WATER);

    // reset mid-line
    set_pix(11'd165, 11'd133, 1'b0, 1'b0, BG);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midline_reset", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                              vblnk_out, rgb_out, read_addr}), 64'd0);
    rst = 1'b0;
    tick(2);
    chk("resume_not_yet", 64'({hcount_out, rgb_out}), 64'd0);
    tick(1);
    chk("resume_hcount", 64'(hcount_out), 64'd165);
    chk("resume_rgb", 64'(rgb_out), 64'(C_HIT));
    hold3("cursor_cleared", 11'd229, 11'd293, 1'b0, C_WATER);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_draw.md
BOARD_DRAW -- requirements
Module: board_draw

Interface
REQ-001 Parameter X_POS, default 64: board left edge, in pixels.
REQ-002 Parameter Y_POS, default 64: board top edge, in pixels.
REQ-003 Parameter X_SIZE, default 16: board width, in cells.
REQ-004 Parameter Y_SIZE, default 16: board height, in cells.
REQ-005 Parameter X_ADDR_WIDTH, default 4: width of the cell x coordinate.
REQ-006 Parameter Y_ADDR_WIDTH, default 4: width of the cell y coordinate.
REQ-007 Parameter DATA_WIDTH, default 2: width of one board cell.
REQ-008 Parameter CELL_SHIFT, default 5: cell edge is 2**CELL_SHIFT pixels.
REQ-009 Port list, one per line: name, direction, width, meaning.
- clk, in, 1: pixel clock; also the board_mem read clock.
- rst, in, 1: synchronous, active-high reset.
- hcount_in, in, 11: horizontal pixel position.
- vcount_in, in, 11: vertical pixel position.
- hsync_in, in, 1: horizontal sync.
- vsync_in, in, 1: vertical sync.
- hblnk_in, in, 1: horizontal blanking.
- vblnk_in, in, 1: vertical blanking.
- rgb_in, in, 12: background pixel colour.
- cursor_x, in, X_ADDR_WIDTH: cell x to highlight.
- cursor_y, in, Y_ADDR_WIDTH: cell y to highlight.
- cursor_en, in, 1: enables the cursor highlight.
- read_addr, out, Y_ADDR_WIDTH+X_ADDR_WIDTH: board_mem read address; bit layout {cell_y, cell_x}.
- read_data, in, DATA_WIDTH: board_mem read data; valid one clk after read_addr is sampled.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, out, same widths as inputs: delayed VGA stream.

Function
REQ-010 All timing outputs SHALL equal the corresponding inputs delayed by exactly 3 clk cycles.
REQ-011 rgb_out SHALL be aligned with the delayed timing outputs.
REQ-012 Stage 1 (cycle N+1): register in_board, cell_x, cell_y, grid flag and read_addr from the cycle-N inputs.
REQ-013 Stage 1 cell coordinates: rel_x = hcount_in - X_POS; cell_x = rel_x >> CELL_SHIFT; same rule for y.
REQ-014 Stage 1 board membership: in_board = 1 iff X_POS <= hcount_in < X_POS + (X_SIZE << CELL_SHIFT), and the same test holds for y.
REQ-015 Stage 1 address: when in_board = 0, read_addr SHALL hold its previous value.
REQ-016 Stage 2 (N+2): the memory returns read_data; stage-1 flags SHALL be carried along.
REQ-017 Stage 3 (N+3): register rgb_out by priority:
- blanking (hblnk or vblnk): 12'h000;
- not in_board: delayed rgb_in;
- grid (low CELL_SHIFT bits of rel_x or rel_y all zero): GRID colour;
- cursor_en and cell equals the latched cursor: CURSOR colour;
- otherwise the colour of the cell state.
REQ-018 Cell state decoding: EMPTY=0 gives WATER, SHIP=1 gives SHIP, HIT=2 gives HIT, MISS=3 gives MISS.
REQ-019 cursor_x, cursor_y and cursor_en SHALL be latched only on the rising edge of vblnk_in, so the highlight is frame-coherent with no mid-frame tearing.
REQ-020 Comparisons SHALL use 12-bit unsigned arithmetic, so that hcount_in < X_POS never wraps into the board.
REQ-021 The last board pixel (rel = (SIZE << CELL_SHIFT) - 1) SHALL be inside the board; rel = SIZE << CELL_SHIFT SHALL be outside it.

Reset
REQ-022 While rst = 1 at a clk edge, every pipeline register, read_addr and every output SHALL be set to 0.
REQ-023 While rst = 1, the latched cursor SHALL be cleared to (0,0) with cursor disabled.
REQ-024 Reset asserted mid-line SHALL take effect on the next edge; outputs resume 3 cycles after rst falls.

Structure
REQ-025 Shared package board_pkg: cell-state enum typedef (EMPTY/SHIP/HIT/MISS) and 12-bit colour constants WATER, SHIP, HIT, MISS, GRID, CURSOR.
REQ-026 The timing delay line SHALL be one sub-module, delay, parameterised by WIDTH and CLK_DEL, with synchronous active-high rst.

Verification
REQ-027 Pipeline latency: random hcount/vcount/sync stream -> every out signal equals its input 3 cycles earlier; rgb_out equals rgb_in outside the board.
REQ-028 Cell read-back: board_mem preloaded cell (y=2, x=3) = HIT; pixel hcount=64+3*32+5, vcount=64+2*32+5 -> read_addr=8'h23 one cycle later, rgb_out=HIT three cycles later.
REQ-029 Edges: hcount=63 -> rgb_in passes through; hcount=64 -> GRID; hcount=575 -> cell colour for x=15; hcount=576 -> rgb_in.
REQ-030 Cursor latching: cursor set to (5,7) mid-frame -> no highlight until after the next vblnk rise; then cell (5,7) shows CURSOR and its grid lines stay GRID.
REQ-031 Blanking and reset: hblnk=1 inside the board -> rgb_out=000; rst pulsed mid-line -> all outputs 0 on the next edge, valid stream resumes 3 cycles later.
